// File: rtl/mdu_pkg.sv
// mdu_pkg
//  Shared definitions for the multiply/divide unit: md_op encodings, FSM
//  state codes, default latencies and small op-classification helpers.
//  Optional feature macro: MDU_MADD_EN (enables MADD/MSUB as launchable ops).
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MTHI  = 4'd4,
    MD_MTLO  = 4'd5,
    MD_MFHI  = 4'd6,
    MD_MFLO  = 4'd7,
    MD_MADD  = 4'd8,
    MD_MSUB  = 4'd9
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_LAT_DEF = 5;
  localparam int unsigned MDU_DIV_LAT_DEF  = 10;
  localparam int unsigned MDU_CNT_W        = 4;

  // Ops that occupy the unit for a multi-cycle run. MADD/MSUB only launch
  // when the accumulate feature is built in; otherwise their codes fall
  // through as no-ops.
  function automatic logic is_arith(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MSUB:                   r = 1'b1;
`else
      MD_MADD, MD_MSUB:                   r = 1'b0;
`endif
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith
//  Combinational 64-bit result for one multiply/divide/accumulate op.
//  Ports:
//    op        in  4   op code (mdu_pkg encodings)
//    a, b      in  32  operands (rs, rt)
//    base_hi   in  32  accumulate base / value kept on no-write
//    base_lo   in  32
//    res_hi    out 32  result HI (remainder for divides)
//    res_lo    out 32  result LO (quotient for divides)
//    div_zero  out 1   divide op with zero divisor; result must not be written
//  MADD/MSUB are always computed here; whether they can launch is decided
//  by the controller (macro MDU_MADD_EN).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] base_hi,
  input  logic [31:0] base_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] a_sx, b_sx, prod_s, prod_u, base, res;
  logic [31:0] b_safe, quo_u, rem_u;
  logic [31:0] mag_a, mag_b, mag_b_safe, q_mag, r_mag, quo_s, rem_s;

  // Sign-extended 64x64 product truncated to 64 bits equals the exact
  // signed 32x32 product.
  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign base   = {base_hi, base_lo};

  // Divisor is forced to 1 when zero so the dividers never see x/0; the
  // result is discarded in that case anyway.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;
  assign quo_u  = a / b_safe;
  assign rem_u  = a % b_safe;

  // Signed divide on magnitudes: 0x80000000 negates to itself, which is
  // exactly 2^31 read as unsigned, so the overflow case 0x80000000 / -1
  // wraps back to 0x80000000 with remainder 0.
  assign mag_a      = a[31] ? (~a + 32'd1) : a;
  assign mag_b      = b[31] ? (~b + 32'd1) : b;
  assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_mag      = mag_a / mag_b_safe;
  assign r_mag      = mag_a % mag_b_safe;
  assign quo_s      = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign rem_s      = a[31] ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res      = base;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        if (b == 32'd0) div_zero = 1'b1;
        else            res = {rem_s, quo_s};
      end
      MD_DIVU: begin
        if (b == 32'd0) div_zero = 1'b1;
        else            res = {rem_u, quo_u};
      end
      MD_MADD:  res = base + prod_s;
      MD_MSUB:  res = base - prod_s;
      default:  res = base;
    endcase
  end

  assign res_hi = res[63:32];
  assign res_lo = res[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl
//  Multiply/divide sequencer for the E stage. Launches one MD op per start
//  pulse, holds busy for the op latency, then commits {hi,lo}. Services
//  MTHI/MTLO writes while idle and MFHI/MFLO reads at any time.
//  Parameters: MULT_LAT (1..15), DIV_LAT (1..15) busy cycles.
//  Ports:
//    clk     in  1   rising-edge clock
//    reset   in  1   asynchronous active-high reset, aborts any op
//    start   in  1   launch pulse for md_op
//    md_op   in  4   op code (mdu_pkg)
//    md_we   in  1   MTHI/MTLO write strobe
//    rs_val  in  32  operand A / move source
//    rt_val  in  32  operand B
//    busy    out 1   op in flight
//    hi, lo  out 32  HI/LO registers
//    md_out  out 32  MFHI -> hi, MFLO -> lo, else 0
//  Optional feature macro: MDU_MADD_EN (MADD/MSUB accumulate ops).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MDU_MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = MDU_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic        md_we,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_LAT);
  localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_LAT);

  mdu_state_e           state, next_state;
  logic [MDU_CNT_W-1:0] cnt;
  logic [3:0]           op_q;
  logic [31:0]          a_q, b_q;
  logic [31:0]          res_hi, res_lo;
  logic                 div_zero;
  logic                 launch;
  logic                 last_cycle;

  assign launch     = (state == ST_IDLE) && start && is_arith(md_op);
  assign last_cycle = (state == ST_RUN) && (cnt == MDU_CNT_W'(1));

  // The result is evaluated from latched operands; hi/lo cannot change
  // during RUN, so they serve directly as the accumulate base.
  mdu_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .base_hi  (hi),
    .base_lo  (lo),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (launch)     next_state = ST_RUN;
      ST_RUN:  if (last_cycle) next_state = ST_IDLE;
      default:                 next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  // Datapath. A start in the same cycle as md_we suppresses the move, and
  // moves arriving during RUN are dropped. A zero divisor runs the full
  // latency but leaves hi/lo untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (launch) begin
      op_q <= md_op;
      a_q  <= rs_val;
      b_q  <= rt_val;
      cnt  <= is_div(md_op) ? DIV_CNT : MULT_CNT;
    end else if (state == ST_RUN) begin
      cnt <= cnt - MDU_CNT_W'(1);
      if (last_cycle && !div_zero) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (md_we && !start) begin
      if (md_op == MD_MTHI) hi <= rs_val;
      if (md_op == MD_MTLO) lo <= rs_val;
    end
  end

  always_comb begin
    md_out = '0;
    if (md_op == MD_MFHI)      md_out = hi;
    else if (md_op == MD_MFLO) md_out = lo;
  end

endmodule
